// File: rtl/sparse_fetch_ctrl.sv
// sparse_fetch_ctrl
//
// Streams packed 256-bit sparse-matrix words from the matrix memory into the
// decoder. Issues in-order word reads starting at a base address, buffers up
// to two returned words in a small FIFO, presents the head word on `data`, and
// drives the decoder's sig / CompStart / EOF controls plus the start/done
// handshake with the top-level compute controller.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   start                one-cycle request to begin a matrix (IDLE only)
//   base_addr, num_words first word address and word count, sampled on start
//   busy, done           high outside IDLE / one-cycle completion pulse
//   mem_req, mem_addr    read request and its word address
//   mem_gnt              request accepted when high together with mem_req
//   mem_rvalid/rdata     in-order read return, latency >= 1
//   data, data_valid     FIFO head word (0 when empty) and its valid flag
//   adv                  decoder pops the head word
//   sig                  pulse on the first cycle the first word is valid
//   CompStart            pulse in the cycle after start is accepted
//   EOF                  head word is the last word of the matrix
module sparse_fetch_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [255:0]      mem_rdata,
  output logic [255:0]      data,
  output logic              data_valid,
  input  logic              adv,
  output logic              sig,
  output logic              CompStart,
  output logic              EOF
);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  consumed_q;
  logic [1:0]        outstanding_q;
  logic              done_q;
  logic              comp_start_q;

  // Two-entry FIFO
  logic [255:0]      buf_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;

  logic              active;
  logic              pop;
  logic              push;
  logic              grant;
  logic              is_last;
  logic              last_pop;
  logic [2:0]        credit;

  always_comb begin
    active     = (state_q == StPrime) || (state_q == StRun);
    data_valid = (count_q != 2'd0);
    pop        = adv && data_valid;
    // Returns with nothing outstanding are stale (e.g. issued before a reset).
    push       = mem_rvalid && (outstanding_q != 2'd0);
    is_last    = (consumed_q == len_q - LEN_W'(1));
    last_pop   = pop && is_last;
    // A pop this cycle frees a slot before any newly granted word can return,
    // which is what lets latency-1 streaming sustain one word per cycle. Once
    // credit exists it can only shrink by a grant, so a pending request holds.
    credit     = {1'b0, count_q} + {1'b0, outstanding_q} - {2'b00, pop};
    mem_req    = active && (issued_q < len_q) && (credit < 3'd2);
    grant      = mem_req && mem_gnt;
    mem_addr   = base_q + ADDR_W'(issued_q);
    data       = data_valid ? buf_q[rd_ptr_q] : '0;
    EOF        = data_valid && is_last;
    sig        = (state_q == StPrime) && data_valid;
    busy       = (state_q != StIdle);
    done       = done_q;
    CompStart  = comp_start_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      base_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      consumed_q    <= '0;
      outstanding_q <= 2'd0;
      done_q        <= 1'b0;
      comp_start_q  <= 1'b0;
    end else begin
      comp_start_q <= 1'b0;
      if (grant) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      if (pop) begin
        consumed_q <= consumed_q + LEN_W'(1);
      end
      outstanding_q <= outstanding_q + {1'b0, grant} - {1'b0, push};

      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q        <= base_addr;
            len_q         <= num_words;
            issued_q      <= '0;
            consumed_q    <= '0;
            outstanding_q <= 2'd0;
            comp_start_q  <= 1'b1;
            state_q       <= (num_words == '0) ? StDone : StPrime;
          end
        end
        StPrime: begin
          if (data_valid) begin
            if (last_pop) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (last_pop) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          // done pulses in the final DONE cycle; entering from IDLE (zero
          // length) spends one extra cycle here before the pulse.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_fetch_ctrl.sv
module tb_sparse_fetch_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  num_words = '0;
  logic         busy, done, mem_req;
  logic [15:0]  mem_addr;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [255:0] mem_rdata = '0;
  logic [255:0] data;
  logic         data_valid;
  logic         adv = 1'b0;
  logic         sig, CompStart, EOF;

  int checks = 0;
  int errors = 0;

  sparse_fetch_ctrl #(.ADDR_W(16), .LEN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .data(data), .data_valid(data_valid), .adv(adv),
    .sig(sig), .CompStart(CompStart), .EOF(EOF)
  );

  always #5 clock = ~clock;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory contents: every address holds a distinct, recognisable word.
  function automatic logic [255:0] word_of(input logic [15:0] a);
    return {8{a, ~a}};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk_b({tag, ".busy"}, busy, 1'b0);
    chk_b({tag, ".done"}, done, 1'b0);
    chk_b({tag, ".mem_req"}, mem_req, 1'b0);
    chk_b({tag, ".data_valid"}, data_valid, 1'b0);
    chk_b({tag, ".sig"}, sig, 1'b0);
    chk_b({tag, ".CompStart"}, CompStart, 1'b0);
    chk_b({tag, ".EOF"}, EOF, 1'b0);
    chk_a({tag, ".mem_addr"}, mem_addr, 16'h0000);
    chk_w({tag, ".data"}, data, '0);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  // One matrix transfer against a queue-based model of memory and buffer.
  // exp_done (cycle after start acceptance at which done is due) is checked
  // when nonzero.
  task automatic run_txn(input logic [15:0] base, input logic [15:0] n, input int adv_pct,
                         input int gnt_pct, input int lat_min, input int lat_max,
                         input int adv_hold, input int exp_done, input string tag);
    logic [255:0] bufq[$];
    pend_t        pend[$];
    int           granted = 0;
    int           popped = 0;
    int           done_c;
    int           first_dv_c = -1;
    int           last_due = 0;
    int           lat;
    int           c;
    bit           prev_req = 1'b0;
    bit           popnow;
    logic [15:0]  prev_addr = '0;

    @(negedge clock);
    start = 1'b1; base_addr = base; num_words = n;
    adv = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    done_c = (n == 16'd0) ? 2 : -1;
    @(negedge clock);
    for (c = 1; ; c++) begin
      // A second start while busy must be ignored.
      start     = (c == 4);
      base_addr = 16'hDEAD;
      num_words = 16'd77;
      adv       = (c > adv_hold) && ($urandom_range(99) < adv_pct);
      mem_gnt   = ($urandom_range(99) < gnt_pct);
      if (pend.size() > 0 && pend[0].due <= c) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word_of(pend[0].addr);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = {8{$urandom()}};
      end
      #1;
      chk_b({tag, ".CompStart"}, CompStart, c == 1);
      chk_b({tag, ".data_valid"}, data_valid, bufq.size() > 0);
      chk_w({tag, ".data"}, data, (bufq.size() > 0) ? bufq[0] : '0);
      chk_b({tag, ".EOF"}, EOF, bufq.size() > 0 && popped == int'(n) - 1);
      chk_b({tag, ".sig"}, sig, bufq.size() > 0 && first_dv_c < 0);
      if (bufq.size() > 0 && first_dv_c < 0) first_dv_c = c;
      chk_b({tag, ".done"}, done, c == done_c);
      chk_b({tag, ".busy"}, busy, done_c < 0 || c <= done_c);
      if (done_c >= 0 && c == done_c + 1) break;
      if (prev_req) begin
        chk_b({tag, ".req_hold"}, mem_req, 1'b1);
        chk_a({tag, ".addr_hold"}, mem_addr, prev_addr);
      end
      if (mem_req) begin
        chk_a({tag, ".mem_addr"}, mem_addr, 16'(base + 16'(granted)));
        chk_b({tag, ".req_within_len"}, granted < int'(n), 1'b1);
      end
      prev_req  = mem_req && !mem_gnt;
      prev_addr = mem_addr;
      popnow    = adv && (bufq.size() > 0);
      if (popnow) begin
        void'(bufq.pop_front());
        popped++;
        if (popped == int'(n)) done_c = c + 1;
      end
      if (mem_rvalid) begin
        bufq.push_back(word_of(pend[0].addr));
        void'(pend.pop_front());
      end
      if (mem_req && mem_gnt) begin
        lat = $urandom_range(lat_max, lat_min);
        if (c + lat <= last_due) lat = last_due + 1 - c;
        last_due = c + lat;
        pend.push_back('{addr: 16'(base + 16'(granted)), due: c + lat});
        granted++;
      end
      chk_b({tag, ".credit"}, (bufq.size() + pend.size()) <= 2, 1'b1);
      if (c > 3000) begin
        errors++;
        $display("FAIL %s.timeout: done not seen after %0d cycles", tag, c);
        reset = 1'b0; #1; reset = 1'b1;
        break;
      end
      @(negedge clock);
    end
    start = 1'b0; adv = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk_i({tag, ".granted"}, granted, int'(n));
    if (exp_done != 0) chk_i({tag, ".done_cycle"}, done_c, exp_done);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] base;
    logic [15:0] n;
    int          adv_pct;
    int          gnt_pct;
    int          lat_min;
    int          lat_max;
    int          adv_hold;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"zero",   16'h1234, 16'd0, 100, 100, 1, 1, 0,  2};
    vecs[1] = '{"single", 16'h0100, 16'd1, 100, 100, 3, 3, 0,  6};
    vecs[2] = '{"stream", 16'h0040, 16'd8, 100, 100, 1, 1, 0, 11};
    vecs[3] = '{"bkpres", 16'h0300, 16'd6, 100, 100, 1, 1, 10, 17};
    vecs[4] = '{"wrap",   16'hFFFE, 16'd4, 100, 100, 1, 1, 0,  7};

    #12;
    chk_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].base, vecs[i].n, vecs[i].adv_pct, vecs[i].gnt_pct, vecs[i].lat_min,
              vecs[i].lat_max, vecs[i].adv_hold, vecs[i].exp_done, vecs[i].tag);
    end

    // Reset with two reads outstanding, then stale returns must be dropped.
    @(negedge clock);
    start = 1'b1; base_addr = 16'h2000; num_words = 16'd10;
    mem_gnt = 1'b1; adv = 1'b0; mem_rvalid = 1'b0;
    @(negedge clock);
    start = 1'b0; #1;
    chk_b("rst.req1", mem_req, 1'b1);
    chk_a("rst.addr1", mem_addr, 16'h2000);
    @(negedge clock); #1;
    chk_b("rst.req2", mem_req, 1'b1);
    chk_a("rst.addr2", mem_addr, 16'h2001);
    @(negedge clock); #1;
    chk_b("rst.req_credit", mem_req, 1'b0);
    reset = 1'b0; #1;
    chk_reset_outputs("rst.mid");
    @(negedge clock);
    reset = 1'b1; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = word_of(16'h2000);
    @(negedge clock);
    mem_rdata = word_of(16'h2001);
    @(negedge clock);
    mem_rvalid = 1'b0; #1;
    chk_reset_outputs("rst.stale");
    run_txn(16'h2100, 16'd3, 100, 100, 1, 2, 0, 0, "rst.after");

    for (int i = 0; i < 20; i++) begin
      run_txn(16'($urandom()), 16'($urandom_range(12, 0)), $urandom_range(100, 30),
              $urandom_range(100, 30), 1, $urandom_range(5, 1), $urandom_range(6, 0), 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparse_fetch_ctrl.md
# sparse_fetch_ctrl

Fetch sequencer that streams packed 256-bit sparse-matrix words from the matrix memory into the `decoder` block. It issues in-order word reads from a base address, buffers up to two returned words, presents the head word on `data` with a valid flag, and drives the decoder's `sig`, `CompStart` and `EOF` controls. It sits between the memory port and `decoder`. It owns the word count and the start/done handshake with the top-level compute controller.

## Interface
- `ADDR_W`, 16: memory word-address width.
- `LEN_W`, 16: width of the word-count field.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `start` in 1: one-cycle request to begin a matrix; honoured only in IDLE.
- `base_addr` in ADDR_W: first word address, sampled when `start` is accepted.
- `num_words` in LEN_W: words to fetch, sampled when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the final word has been consumed.
- `mem_req` out 1: read request valid.
- `mem_addr` out ADDR_W: read address, stable while `mem_req` is high.
- `mem_gnt` in 1: request accepted this cycle when high together with `mem_req`.
- `mem_rvalid` in 1: read data return; returns arrive in order, any latency ≥1.
- `mem_rdata` in 256: returned word.
- `data` out 256: head buffered word, feeds `decoder.data`.
- `data_valid` out 1: `data` holds a valid word.
- `adv` in 1: decoder finished with the head word; pops it.
- `sig` out 1: one-cycle pulse on the first cycle the first word is valid.
- `CompStart` out 1: one-cycle pulse in the cycle after `start` is accepted.
- `EOF` out 1: high while the head word is the last word of the matrix.

## Operation
- FSM states:
  - IDLE: waits for `start`. On `start`, latches `base_addr` and `num_words`, clears the counters and goes to PRIME. If `num_words`==0, it goes straight to DONE instead.
  - PRIME: requests issue. Moves to RUN when `data_valid` first rises; `sig` pulses that same cycle.
  - RUN: continues until the word popped by `adv` is the last word, then goes to DONE.
  - DONE: pulses `done` for one cycle, then returns to IDLE.
- Buffer: 2-entry FIFO. `outstanding` counts granted but unreturned reads (0..2). `issued` counts granted reads (LEN_W bits).
- Request rule: `mem_req` = (state is PRIME or RUN) && `issued` < `num_words` && (FIFO occupancy + `outstanding`) < 2. Once raised, `mem_req` holds with a constant `mem_addr` until `mem_gnt`.
- Address generation: `mem_addr` = latched base + `issued`, computed modulo 2^ADDR_W (wraps past the top of memory).
- Returns: `mem_rvalid` pushes `mem_rdata` into the FIFO. Because of credit gating the FIFO never overflows. If a return arrives with `outstanding`==0, it is dropped.
- Pop: `adv` && `data_valid` pops the head and increments `consumed`. `adv` with `data_valid` low is ignored.
- Same-cycle push and pop: both happen; occupancy is unchanged.
- Head output: `data` = FIFO head, or 0 when the FIFO is empty.
- EOF flag: `EOF` = `data_valid` && (`consumed` == `num_words`−1).
- `start` in any state other than IDLE is ignored.

## Timing
- Reset values: `busy`, `done`, `mem_req`, `data_valid`, `sig`, `CompStart` and `EOF` are 0. `mem_addr` and `data` are 0. State is IDLE. All counters are 0.
- Cycle S is `start` accepted:
  - S+1: `CompStart`=1; `mem_req` may be high.
  - S+1 is also the earliest `mem_gnt`.
- Read latency: a word returned by `mem_rvalid` at cycle R is on `data` with `data_valid`=1 at R+1. No combinational path exists from `mem_rdata` to `data`.
- Pop latency: a pop at cycle P shows the next head at P+1, provided it was already buffered.
- Completion: a pop of the last word at cycle L gives `done`=1 at L+1 and `busy`=0 at L+2.
- Reset mid-operation:
  - Returns to IDLE immediately.
  - The FIFO is flushed and `outstanding` is cleared.
  - Late `mem_rvalid` returns from before reset are dropped.
- Sustained throughput: one word per cycle when `mem_gnt` is held high, read latency is 1 and `adv` is high every cycle.

## Test plan
- Zero length: `start`, `num_words`=0 → no `mem_req`, `done` at S+2, `CompStart` at S+1, `sig` never asserted.
- Single word: `num_words`=1, base 0x0100, latency 3 → one request at 0x0100. `data_valid` and `EOF` rise together with `sig`. `adv` → `done` next cycle.
- Streaming: `num_words`=8, `mem_gnt` always high, latency 1, `adv` always high → addresses base..base+7. Eight consecutive valid words after the first, in order. `EOF` only on word 7.
- Backpressure: `num_words`=6, `adv` low for 10 cycles → at most 2 words buffered plus outstanding. `mem_req` drops. No word is lost or duplicated once `adv` resumes.
- Address wrap: `base_addr`=0xFFFE, `num_words`=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-run: drive `reset` low with 2 reads outstanding, release, then inject stale `mem_rvalid` → outputs at reset values, stale data dropped. A new `start` then completes correctly.
